gray_seq_ctrl: RTL and testbench

Sequencer for the team's binary-to-Gray converter datapath. On a start command it steps an internal binary counter up or down from a seed for a programmed number of beats. Each beat presents the binary value and its Gray encoding on a valid/ready output stream. It tracks counter wrap-around and signals completion with a one-cycle pulse. It sits between a command source (testbench or top-level FSM) and any consumer of Gray-coded sequences, such as a position encoder model or an async-FIFO pointer checker.

---
 rtl/gray_seq_ctrl.sv | 78 +++++++
 tb/tb_gray_seq_ctrl.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/gray_seq_ctrl.sv
// gray_seq_ctrl: seeded up/down binary counter sequencer streaming binary and Gray-coded beats
module gray_seq_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             dir,
  input  logic [WIDTH-1:0] seed,
  input  logic [WIDTH:0]   len,
  input  logic             abort,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] bin_out,
  output logic [WIDTH-1:0] gray_out,
  output logic             busy,
  output logic             done,
  output logic             wrap
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state;
  logic             dir_r;
  logic [WIDTH:0]   remaining;
  logic             xfer;
  logic             last;
  logic             at_term;
  assign xfer     = out_valid && out_ready;
  assign last     = remaining == (WIDTH+1)'(1);
  assign at_term  = bin_out == {WIDTH{~dir_r}};
  assign gray_out = bin_out ^ (bin_out >> 1);
  always_ff @(posedge clk)
    if (!rst_n) begin
      state     <= IDLE;
      dir_r     <= 1'b0;
      remaining <= '0;
      bin_out   <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      wrap      <= 1'b0;
    end else
      case (state)
        IDLE: begin
          out_valid <= 1'b0;
          done      <= 1'b0;
          busy      <= 1'b0;
          if (start) begin
            dir_r     <= dir;
            bin_out   <= seed;
            remaining <= len;
            wrap      <= 1'b0;
            busy      <= 1'b1;
            state     <= (len != '0) ? RUN : DONE;
            out_valid <= len != '0;
            done      <= len == '0;
          end
        end
        RUN: begin
          if (xfer) begin
            remaining <= remaining - (WIDTH+1)'(1);
            if (at_term && !last) wrap <= 1'b1;
          end
          // the final or aborting beat leaves bin_out on the last presented value
          if (abort || (xfer && last)) begin
            state     <= DONE;
            out_valid <= 1'b0;
            done      <= 1'b1;
          end else if (xfer)
            bin_out <= dir_r ? bin_out - WIDTH'(1) : bin_out + WIDTH'(1);
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_gray_seq_ctrl.sv
// tb_gray_seq_ctrl: directed and randomized runs checked against a beat-list reference model
module tb_gray_seq_ctrl;
  localparam int W = 4;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         dir = 1'b0;
  logic [W-1:0] seed = '0;
  logic [W:0]   len = '0;
  logic         abort = 1'b0;
  logic         out_ready = 1'b0;
  logic         out_valid;
  logic [W-1:0] bin_out;
  logic [W-1:0] gray_out;
  logic         busy;
  logic         done;
  logic         wrap;
  int           vecs = 0;
  int           errs = 0;

  gray_seq_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dir(dir), .seed(seed), .len(len),
    .abort(abort), .out_ready(out_ready), .out_valid(out_valid), .bin_out(bin_out),
    .gray_out(gray_out), .busy(busy), .done(done), .wrap(wrap)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] gray(input logic [W-1:0] b);
    logic [W-1:0] g;
    g[W-1] = b[W-1];
    for (int i = 0; i < W - 1; i++) g[i] = b[i+1] ^ b[i];
    return g;
  endfunction

  // k-th beat of a run is seed stepped k times, modulo 2^W
  function automatic logic [W-1:0] beat(input logic [W-1:0] s, input logic d, input int k);
    int v;
    v = d ? (int'(s) - k) : (int'(s) + k);
    v = ((v % (1 << W)) + (1 << W)) % (1 << W);
    return W'(v);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // abort_at: beat index on which abort is raised (-1 = never); stalls apply on stall_beat
  task automatic run(input logic [W-1:0] s, input logic d, input int n, input int abort_at,
                     input int stall_pct, input int stall_beat, input int stall_n, input bit poke);
    int  k = 0;
    int  cyc = 0;
    int  stl = stall_n;
    bit  ab = 0;
    bit  w = 0;
    logic [W-1:0] eb;
    @(negedge clk);
    start = 1'b1; seed = s; dir = d; len = (W+1)'(n);
    @(negedge clk);
    start = 1'b0; seed = W'($urandom); dir = 1'($urandom); len = (W+1)'($urandom);
    while (!ab && k < n && cyc < 200) begin
      eb = beat(s, d, k);
      chk("valid", out_valid, 1);
      chk("bin", bin_out, eb);
      chk("gray", gray_out, gray(eb));
      chk("busy", busy, 1);
      if (k == stall_beat && stl > 0) begin
        out_ready = 1'b0;
        stl--;
      end else out_ready = $urandom_range(99) >= stall_pct;
      abort = k == abort_at;
      start = poke && ($urandom_range(2) == 0);
      @(posedge clk);
      if (out_ready) begin
        if (k < n - 1 && eb == (d ? W'(0) : {W{1'b1}})) w = 1;
        k++;
      end
      if (abort) ab = 1;
      @(negedge clk);
      out_ready = 1'b0; abort = 1'b0; start = 1'b0;
      cyc++;
    end
    chk("timeout", cyc < 200, 1);
    chk("done_pulse", done, 1);
    chk("done_busy", busy, 1);
    chk("done_valid", out_valid, 0);
    chk("done_wrap", wrap, w);
    eb = (n == 0 || k == 0) ? s : beat(s, d, k - 1);
    chk("done_bin", bin_out, eb);
    @(negedge clk);
    chk("idle_done", done, 0);
    chk("idle_busy", busy, 0);
    chk("idle_valid", out_valid, 0);
    chk("idle_bin", bin_out, eb);
    chk("idle_gray", gray_out, gray(eb));
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_bin", bin_out, 0);
    chk("rst_gray", gray_out, 0);
    chk("rst_wrap", wrap, 0);
    rst_n = 1'b1;
    run(4'd0, 1'b0, 4, -1, 0, -1, 0, 0);
    run(4'd14, 1'b0, 4, -1, 0, -1, 0, 0);
    run(4'd1, 1'b1, 3, -1, 0, -1, 0, 0);
    run(4'd5, 1'b0, 3, -1, 0, 1, 3, 1);
    run(4'd9, 1'b0, 0, -1, 0, -1, 0, 0);
    run(4'd0, 1'b0, 8, 2, 0, -1, 0, 0);
    run(4'd0, 1'b0, 16, -1, 0, -1, 0, 0);
    run(4'd7, 1'b1, 16, -1, 20, -1, 0, 1);
    run(4'd15, 1'b1, 16, -1, 0, -1, 0, 0);
    // mid-run reset: no done pulse, reset values next cycle
    @(negedge clk);
    start = 1'b1; seed = 4'd13; dir = 1'b0; len = 5'd6; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("mrst_valid", out_valid, 0);
      chk("mrst_busy", busy, 0);
      chk("mrst_done", done, 0);
      chk("mrst_wrap", wrap, 0);
      chk("mrst_bin", bin_out, 0);
      chk("mrst_gray", gray_out, 0);
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("mrst_nodone", done, 0);
    end
    out_ready = 1'b0;
    repeat (25) run(W'($urandom), 1'($urandom), int'($urandom_range(16)),
                    ($urandom_range(3) == 0) ? int'($urandom_range(15)) : -1,
                    30, int'($urandom_range(15)), int'($urandom_range(3)), 1);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
